// File: rtl/stream_arb_pkg.sv
// Shared arbitration-mode encodings and a width helper for the stream mux.
package stream_arb_pkg;

    localparam int ARB_EXTERNAL    = 0;
    localparam int ARB_ROUND_ROBIN = 1;
    localparam int ARB_FIXED_PRIO  = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first request after ptr_i wins.
// Assumes NCH is a power of two so the wrap is a plain truncation.
module rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int  NCH = 4,
    localparam int IW  = clog2(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_oh_o,
    output logic [IW-1:0]  gnt_idx_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = ptr_i + IW'(k);
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                gnt_idx_o = cand;
            end
        end
        if (found) begin
            gnt_oh_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// Registered N-to-1 stream mux with valid/ready flow control, packet locking
// and external, round-robin or fixed-priority channel arbitration.
module stream_arb_mux
    import stream_arb_pkg::*;
#(
    parameter int  BUSWIDTH = 32,
    parameter int  SELWIDTH = 2,
    parameter int  ARB_MODE = ARB_ROUND_ROBIN,
    localparam int NCH      = 2 ** SELWIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BUSWIDTH*NCH-1:0] in_data,
    input  logic [NCH-1:0]          in_valid,
    input  logic [NCH-1:0]          in_last,
    output logic [NCH-1:0]          in_ready,
    input  logic [SELWIDTH-1:0]     select,
    output logic [BUSWIDTH-1:0]     out_data,
    output logic [SELWIDTH-1:0]     out_sel,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic                out_valid_q, out_valid_d;
    logic [BUSWIDTH-1:0] out_data_q, out_data_d;
    logic [SELWIDTH-1:0] out_sel_q, out_sel_d;
    logic                out_last_q, out_last_d;
    logic                locked_q, locked_d;
    logic [SELWIDTH-1:0] lock_ch_q, lock_ch_d;
    logic [SELWIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [SELWIDTH-1:0] arb_ptr;
    logic [NCH-1:0]      arb_oh;
    logic [SELWIDTH-1:0] arb_idx;
    logic [NCH-1:0]      grant_oh;
    logic [SELWIDTH-1:0] grant;
    logic                can_load;
    logic                accept;

    // Fixed priority reuses the rotating arbiter with the pointer parked on
    // the top channel, so the search always starts at channel 0.
    assign arb_ptr = (ARB_MODE == ARB_FIXED_PRIO) ? {SELWIDTH{1'b1}} : rr_ptr_q;

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr_arbiter (
        .req_i     (in_valid),
        .ptr_i     (arb_ptr),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    always_comb begin
        grant_oh = '0;
        grant    = '0;
        if (locked_q) begin
            grant              = lock_ch_q;
            grant_oh[lock_ch_q] = 1'b1;
        end else if (ARB_MODE == ARB_EXTERNAL) begin
            grant           = select;
            grant_oh[select] = 1'b1;
        end else begin
            grant    = arb_idx;
            grant_oh = arb_oh;
        end
    end

    assign can_load = !out_valid_q || out_ready;
    assign in_ready = can_load ? grant_oh : '0;
    assign accept   = can_load && in_valid[grant];

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        locked_d    = locked_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[BUSWIDTH*grant +: BUSWIDTH];
            out_sel_d   = grant;
            out_last_d  = in_last[grant];
            locked_d    = !in_last[grant];
            lock_ch_d   = grant;
            if (ARB_MODE == ARB_ROUND_ROBIN) begin
                rr_ptr_d = grant;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
            locked_q    <= 1'b0;
            lock_ch_q   <= '0;
            rr_ptr_q    <= {SELWIDTH{1'b1}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            locked_q    <= locked_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;

endmodule
